// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the Y86-64 register file: register indices, status codes, FSM states.
package regfile_wb_pkg;

  typedef enum logic [3:0] {
    RAX = 4'h0, RCX, RDX, RBX, RSP, RBP, RSI, RDI,
    R8, R9, R10, R11, R12, R13, R14,
    RNONE = 4'hF
  } reg_idx_e;

  typedef enum logic [2:0] {
    SBUB = 3'd0,
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_e;

  typedef enum logic [1:0] {
    RF_CLEAR = 2'd0,
    RF_RUN   = 2'd1,
    RF_HALT  = 2'd2
  } rf_state_e;

  function automatic logic idx_ok(input logic [3:0] idx, input int nreg);
    return (idx != RNONE) && (int'({28'd0, idx}) < nreg);
  endfunction

  function automatic logic is_fault(input logic [2:0] stat);
    return (stat == SHLT) || (stat == SADR) || (stat == SINS);
  endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// Writeback-stage write ports, decode-stage read ports and status of the register file.
interface regfile_wb_if
  import regfile_wb_pkg::*;
#(
  parameter int DW = 64
) ();
  // No handshake: a write is offered every cycle and commits on the edge when the
  // file is running and W_stat_i is SAOK; reads are purely combinational.
  logic [2:0]    W_stat_i;
  logic [3:0]    W_dstE_i;
  logic [DW-1:0] W_valE_i;
  logic [3:0]    W_dstM_i;
  logic [DW-1:0] W_valM_i;
  logic [3:0]    d_srcA_i;
  logic [3:0]    d_srcB_i;
  logic [DW-1:0] rvalA_o;
  logic [DW-1:0] rvalB_o;
  logic          busy_o;
  logic          halted_o;
  logic [31:0]   wr_cnt_o;
  rf_state_e     dbg_state_o;

  modport master (
    output W_stat_i, W_dstE_i, W_valE_i, W_dstM_i, W_valM_i, d_srcA_i, d_srcB_i,
    input  rvalA_o, rvalB_o, busy_o, halted_o, wr_cnt_o, dbg_state_o
  );

  modport slave (
    input  W_stat_i, W_dstE_i, W_valE_i, W_dstM_i, W_valM_i, d_srcA_i, d_srcB_i,
    output rvalA_o, rvalB_o, busy_o, halted_o, wr_cnt_o, dbg_state_o
  );
endinterface

// File: rtl/regfile_wb_rdport.sv
// One read port: index range check and, with REGFILE_BYPASS_EN, same-cycle write forwarding (M over E).
module regfile_wb_rdport
  import regfile_wb_pkg::*;
#(
  parameter int DW   = 64,
  parameter int NREG = 15
) (
  input  logic          i_rd_en,
  input  logic [3:0]    i_idx,
  input  logic [DW-1:0] i_regs [NREG],
  input  logic          i_we_e,
  input  logic [3:0]    i_dst_e,
  input  logic [DW-1:0] i_val_e,
  input  logic          i_we_m,
  input  logic [3:0]    i_dst_m,
  input  logic [DW-1:0] i_val_m,
  output logic [DW-1:0] o_rval
);

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    o_rval = '0;
    if (i_rd_en && idx_ok(i_idx, NREG)) begin
      o_rval = i_regs[i_idx];
      if (i_we_e && (i_dst_e == i_idx)) o_rval = i_val_e;
      if (i_we_m && (i_dst_m == i_idx)) o_rval = i_val_m;
    end
  end
`else
  logic w_unused_byp;
  assign w_unused_byp = ^{i_we_e, i_dst_e, i_val_e, i_we_m, i_dst_m, i_val_m};

  always_comb begin
    o_rval = '0;
    if (i_rd_en && idx_ok(i_idx, NREG)) o_rval = i_regs[i_idx];
  end
`endif

endmodule

// File: rtl/regfile_wb.sv
// Y86-64 register file with clear/run/halt FSM and saturating write counter.
// Optional same-cycle read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DW             = 64,
  parameter int NREG           = 15,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  regfile_wb_if.slave  bus
);

  localparam rf_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? RF_CLEAR : RF_RUN;

  logic [DW-1:0] r_regs [NREG];
  rf_state_e     r_state;
  rf_state_e     w_next;
  logic [3:0]    r_clr_idx;
  logic [31:0]   r_wr_cnt;
  logic          w_run_ok;
  logic          w_we_e;
  logic          w_we_m;
  logic          w_same;
  logic [1:0]    w_nwr;
  logic [32:0]   w_cnt_sum;

  assign w_run_ok  = (r_state == RF_RUN) && (bus.W_stat_i == SAOK);
  assign w_we_e    = w_run_ok && idx_ok(bus.W_dstE_i, NREG);
  assign w_we_m    = w_run_ok && idx_ok(bus.W_dstM_i, NREG);
  // Both ports on one register is a single architectural write (popq %rsp).
  assign w_same    = w_we_e && w_we_m && (bus.W_dstE_i == bus.W_dstM_i);
  assign w_nwr     = {1'b0, w_we_e} + {1'b0, w_we_m} - {1'b0, w_same};
  assign w_cnt_sum = {1'b0, r_wr_cnt} + {31'd0, w_nwr};

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= RESET_STATE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RF_CLEAR: if (r_clr_idx == 4'(NREG - 1)) w_next = RF_RUN;
      RF_RUN:   if (is_fault(bus.W_stat_i)) w_next = RF_HALT;
      RF_HALT:  w_next = RF_HALT;
      default:  w_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_clr_idx <= '0;
      r_wr_cnt  <= '0;
      if (CLEAR_ON_RESET == 0) begin
        for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end
    end else begin
      if (r_state == RF_CLEAR) begin
        r_regs[r_clr_idx] <= '0;
        r_clr_idx         <= r_clr_idx + 4'd1;
      end
      // M is assigned last so it wins when both ports target one register.
      if (w_we_e) r_regs[bus.W_dstE_i] <= bus.W_valE_i;
      if (w_we_m) r_regs[bus.W_dstM_i] <= bus.W_valM_i;
      r_wr_cnt <= w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
    end
  end

  regfile_wb_rdport #(.DW(DW), .NREG(NREG)) u_rd_a (
    .i_rd_en (r_state != RF_CLEAR),
    .i_idx   (bus.d_srcA_i),
    .i_regs  (r_regs),
    .i_we_e  (w_we_e),
    .i_dst_e (bus.W_dstE_i),
    .i_val_e (bus.W_valE_i),
    .i_we_m  (w_we_m),
    .i_dst_m (bus.W_dstM_i),
    .i_val_m (bus.W_valM_i),
    .o_rval  (bus.rvalA_o)
  );

  regfile_wb_rdport #(.DW(DW), .NREG(NREG)) u_rd_b (
    .i_rd_en (r_state != RF_CLEAR),
    .i_idx   (bus.d_srcB_i),
    .i_regs  (r_regs),
    .i_we_e  (w_we_e),
    .i_dst_e (bus.W_dstE_i),
    .i_val_e (bus.W_valE_i),
    .i_we_m  (w_we_m),
    .i_dst_m (bus.W_dstM_i),
    .i_val_m (bus.W_valM_i),
    .o_rval  (bus.rvalB_o)
  );

  assign bus.busy_o      = (r_state == RF_CLEAR);
  assign bus.halted_o    = (r_state == RF_HALT);
  assign bus.wr_cnt_o    = r_wr_cnt;
  assign bus.dbg_state_o = r_state;

endmodule
